div_stall_unit: RTL and testbench

//  Multi-cycle 32-bit MIPS DIV/DIVU unit in the EX stage.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_stall_unit_step.sv | 22 ++
 rtl/div_stall_unit.sv | 139 +++++++++++++
 tb/tb_div_stall_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle MIPS DIV/DIVU unit.
// State encoding and default widths.
package div_pkg;

  localparam int WIDTH_D = 32;
  localparam int CNT_W_D = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_stall_unit_step.sv
// One restoring shift-subtract iteration (combinational).
// Ports: rem_i/quo_i/dvs_i in, rem_o/quo_o out.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] dif;

  // rem < dvs always holds, so the top bit of dif is a clean sign bit.
  assign shf   = {rem_i, quo_i[WIDTH-1]};
  assign dif   = shf - {1'b0, dvs_i};
  assign rem_o = dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~dif[WIDTH]};

endmodule

// File: rtl/div_stall_unit.sv
// Multi-cycle 32-bit DIV/DIVU for EX; drives pipeline stall and HI/LO result.
// Ports: clk, rst (sync, high), start_i, signed_i, annul_i, a_i, b_i ->
//   stall_o (~en of pipeline regs), ready_o (1-cycle pulse),
//   result_o = {remainder, quotient}.
// Option: define DIV_EARLY_OUT_EN to finish at once when |a| < |b|.
module div_stall_unit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  div_state_t state, nxt;

  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0]   rem_n, quo_n;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] res_q;
  logic               negq, negr;
  logic               sa, sb;
  logic               accept, early, last;

  assign sa     = signed_i & a_i[WIDTH-1];
  assign sb     = signed_i & b_i[WIDTH-1];
  assign abs_a  = sa ? -a_i : a_i;
  assign abs_b  = sb ? -b_i : b_i;
  assign accept = start_i & ~annul_i;
  assign last   = (cnt == CNT_W'(WIDTH-1));

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // MIN/-1 needs no special case: negating 0x80000000 wraps to itself.
  assign q_fix = negq ? -quo_q : quo_q;
  assign r_fix = negr ? -rem_q : rem_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  always_comb begin
    nxt     = state;
    stall_o = 1'b0;
    ready_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (b_i == '0)  nxt = ZERO;
          else if (early) nxt = DONE;
          else            nxt = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (last) nxt = DONE;
      end
      ZERO: begin
        stall_o = 1'b1;
        nxt     = DONE;
      end
      DONE: begin
        ready_o = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (annul_i) begin
      nxt     = IDLE;
      stall_o = 1'b0;
      ready_o = 1'b0;
    end
  end

  // Result is visible in the DONE cycle itself, then held.
  assign result_o = ready_o ? {r_fix, q_fix} : res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      negq  <= 1'b0;
      negr  <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && accept) begin
        cnt <= '0;
        if (b_i == '0) begin
          rem_q <= a_i;
          quo_q <= '1;
          negq  <= 1'b0;
          negr  <= 1'b0;
        end else if (early) begin
          rem_q <= a_i;
          quo_q <= '0;
          negq  <= 1'b0;
          negr  <= 1'b0;
        end else begin
          rem_q <= '0;
          quo_q <= abs_a;
          dvs_q <= abs_b;
          negq  <= sa ^ sb;
          negr  <= sa;
        end
      end
      if (state == BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt   <= cnt + CNT_W'(1);
      end
      if (ready_o) res_q <= {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit.
// Cycle model from arithmetic + latency rules; random and directed ops.
`timescale 1ns/1ps
module tb_div_stall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic        stall_seen, rdy_seen;
  logic [63:0] res_seen;

  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_held = '0;

  div_stall_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_div(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int lat_of(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (ma < mb) return 1;
    end
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        es, er;
    logic [63:0] eres;
    if (rst) begin
      m_pend = 1'b0;
      m_held = '0;
    end else begin
      es   = 1'b0;
      er   = 1'b0;
      eres = m_held;
      if (annul_i) begin
        m_pend = 1'b0;
      end else if (m_pend && m_left == 0) begin
        er     = 1'b1;
        eres   = m_res;
        m_held = m_res;
        m_pend = 1'b0;
      end else if (m_pend) begin
        es = 1'b1;
        m_left--;
      end else if (start_i) begin
        es     = 1'b1;
        m_pend = 1'b1;
        m_res  = ref_div(a_i, b_i, signed_i);
        m_left = lat_of(a_i, b_i, signed_i) - 1;
      end
      chk("stall", 64'(stall_o), 64'(es));
      chk("ready", 64'(ready_o), 64'(er));
      chk("result", result_o, eres);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    stall_seen = stall_o;
    rdy_seen   = ready_o;
    res_seen   = result_o;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [63:0] res,
                        output int lat);
    start_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    res      = '0;
    lat      = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rdy_seen) begin
        res = res_seen;
        lat = k;
        break;
      end
      a_i = $urandom;
      b_i = $urandom;
    end
    start_i = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no ready for %h/%h", a, b);
    end
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    logic [31:0] ra, rb;
    logic        rs;
    int          r;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    a_i = '0; b_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_stall", 64'(stall_seen), 64'd0);
    chk("rst_ready", 64'(rdy_seen), 64'd0);
    chk("rst_result", res_seen, 64'd0);

    run_op(32'd100, 32'd7, 1'b0, res, lat);
    chk("divu_100_7", res, 64'h00000002_0000000E);
    chk("divu_lat", 64'(lat), 64'd33);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
    chk("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
    chk("div_min_m1", res, 64'h00000000_80000000);

    run_op(32'd5, 32'd0, 1'b0, res, lat);
    chk("divu_5_0", res, 64'h00000005_FFFFFFFF);
    chk("div0_lat", 64'(lat), 64'd2);

    start_i = 1'b1; a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk("annul_stall", 64'(stall_seen), 64'd0);
    annul_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("annul_noready", 64'(rdy_seen), 64'd0);
      chk("annul_hold", res_seen, 64'h00000005_FFFFFFFF);
    end
    run_op(32'd9, 32'd3, 1'b0, res, lat);
    chk("divu_9_3", res, 64'h00000000_00000003);

    start_i = 1'b1; annul_i = 1'b1;
    tick();
    chk("annul_idle", 64'(stall_seen), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    tick();
    chk("annul_idle_nxt", 64'(stall_seen), 64'd0);

    start_i = 1'b1; a_i = 32'd1000; b_i = 32'd3;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_stall", 64'(stall_seen), 64'd0);
    chk("midrst_ready", 64'(rdy_seen), 64'd0);
    chk("midrst_result", res_seen, 64'd0);

    run_op(32'd3, 32'd9, 1'b0, res, lat);
    chk("divu_3_9", res, 64'h00000003_00000000);
`ifdef DIV_EARLY_OUT_EN
    chk("early_lat", 64'(lat), 64'd1);
`else
    chk("early_lat", 64'(lat), 64'd33);
`endif

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      rb = 32'd0;
      else if (r < 4)  rb = $urandom_range(1, 20);
      else if (r == 4) rb = 32'hFFFF_FFFF;
      else             rb = $urandom;
      if (r == 4)                        ra = 32'h8000_0000;
      else if ($urandom_range(0, 1) == 1) ra = $urandom;
      else                               ra = $urandom_range(0, 100);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, res, lat);
      chk("rand_res", res, ref_div(ra, rb, rs));
      chk("rand_lat", 64'(lat), 64'(lat_of(ra, rb, rs)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
